peripheral_register_file: RTL and testbench



---
 rtl/peripheral_register_file.sv | 107 ++++++++++
 tb/tb_peripheral_register_file.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/peripheral_register_file.sv
// peripheral_register_file: word-addressed register map for display, seven-segment and LED control plus switch/button status.
// Defining PERIPH_IRQ_EN adds the IRQ_MASK register at 0x7 and a registered press interrupt.
module peripheral_register_file #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clock_100mhz,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [2:0]        display_control,
    output logic [31:0]       sevenseg_data,
    output logic [15:0]       mono_led_data,
    input  logic [15:0]       switch_state,
    input  logic [4:0]        button_state,
    output logic              irq
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_next;
    logic accept, wr, rd;
    logic [DATA_W-1:0] seg_lo, rdata;
    logic [4:0] btn_prev, pressed, clr;
`ifdef PERIPH_IRQ_EN
    logic [4:0] mask;
`endif

    always_ff @(posedge clock_100mhz or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        if (state == IDLE) begin
            req_ready = reset_n;
            state_next = req_valid ? RESP : IDLE;
        end else begin
            resp_valid = 1'b1;
            state_next = resp_ready ? IDLE : RESP;
        end
    end

    assign accept = req_valid & req_ready;
    assign wr = accept & req_write;
    assign rd = accept & ~req_write;
    // A PRESSED read clears every flag; a write clears only the bits written 1.
    assign clr = (rd && req_addr == ADDR_W'(6)) ? 5'h1f :
                 (wr && req_addr == ADDR_W'(6)) ? req_wdata[4:0] : 5'h00;

    always_comb begin
        rdata = '0;
        case (req_addr)
            ADDR_W'(0): rdata = DATA_W'(display_control);
            ADDR_W'(1): rdata = seg_lo;
            ADDR_W'(2): rdata = sevenseg_data[31:16];
            ADDR_W'(3): rdata = mono_led_data;
            ADDR_W'(4): rdata = switch_state;
            ADDR_W'(5): rdata = DATA_W'(button_state);
            ADDR_W'(6): rdata = DATA_W'(pressed);
`ifdef PERIPH_IRQ_EN
            ADDR_W'(7): rdata = DATA_W'(mask);
`endif
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            display_control <= '0;
            sevenseg_data <= '0;
            mono_led_data <= '0;
            seg_lo <= '0;
            resp_rdata <= '0;
            pressed <= '0;
            btn_prev <= '1;
        end else begin
            btn_prev <= button_state;
            pressed <= (pressed & ~clr) | (button_state & ~btn_prev);
            if (accept) resp_rdata <= req_write ? '0 : rdata;
            if (wr && req_addr == ADDR_W'(0)) display_control <= req_wdata[2:0];
            if (wr && req_addr == ADDR_W'(1)) seg_lo <= req_wdata;
            if (wr && req_addr == ADDR_W'(2)) sevenseg_data <= {req_wdata, seg_lo};
            if (wr && req_addr == ADDR_W'(3)) mono_led_data <= req_wdata;
        end
    end

`ifdef PERIPH_IRQ_EN
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
            irq <= 1'b0;
        end else begin
            if (wr && req_addr == ADDR_W'(7)) mask <= req_wdata[4:0];
            irq <= |(pressed & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_peripheral_register_file.sv
// tb_peripheral_register_file: directed vector table plus hand sequences for peripheral_register_file.
// Expectations adapt to whether PERIPH_IRQ_EN is defined.
module tb_peripheral_register_file;
`ifdef PERIPH_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n, req_valid, req_ready, req_write, resp_valid, resp_ready, irq;
    logic [3:0] req_addr;
    logic [15:0] req_wdata, resp_rdata, mono_led_data, switch_state;
    logic [2:0] display_control;
    logic [31:0] sevenseg_data, seg_pre, seg_acc;
    logic [4:0] button_state;
    logic irq_acc;
    logic [15:0] r;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] sw;
        logic [15:0] er;
        logic [2:0]  edc;
        logic [31:0] eseg;
        logic [15:0] eled;
    } vec_t;
    vec_t tbl[20];

    peripheral_register_file dut (
        .clock_100mhz(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .display_control(display_control), .sevenseg_data(sevenseg_data),
        .mono_led_data(mono_led_data), .switch_state(switch_state),
        .button_state(button_state), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic xact(input logic w, input logic [3:0] a, input logic [15:0] d,
                        input logic [4:0] b, output logic [15:0] rd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; button_state = b;
        seg_pre = sevenseg_data;
        n = 0;
        while (!req_ready && n < 16) begin @(negedge clk); n++; end
        chk("req_ready_idle", {31'b0, req_ready}, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        seg_acc = sevenseg_data;
        irq_acc = irq;
        chk("resp_latency", {31'b0, resp_valid}, 1);
        rd = resp_rdata;
        @(posedge clk); #1;
        chk("resp_done", {31'b0, resp_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 4'h6, 16'h0000, 16'h1234, 16'h0000, 3'd0, 32'h0, 16'h0};
        tbl[1]  = '{1, 4'h1, 16'hBEEF, 16'h1234, 16'h0000, 3'd0, 32'h0, 16'h0};
        tbl[2]  = '{0, 4'h1, 16'h0000, 16'h1234, 16'hBEEF, 3'd0, 32'h0, 16'h0};
        tbl[3]  = '{1, 4'h2, 16'hDEAD, 16'h1234, 16'h0000, 3'd0, 32'hDEADBEEF, 16'h0};
        tbl[4]  = '{0, 4'h2, 16'h0000, 16'h1234, 16'hDEAD, 3'd0, 32'hDEADBEEF, 16'h0};
        tbl[5]  = '{1, 4'h0, 16'h0007, 16'h1234, 16'h0000, 3'd7, 32'hDEADBEEF, 16'h0};
        tbl[6]  = '{0, 4'h0, 16'h0000, 16'h1234, 16'h0007, 3'd7, 32'hDEADBEEF, 16'h0};
        tbl[7]  = '{1, 4'h0, 16'hFFFA, 16'h1234, 16'h0000, 3'd2, 32'hDEADBEEF, 16'h0};
        tbl[8]  = '{0, 4'h0, 16'h0000, 16'h1234, 16'h0002, 3'd2, 32'hDEADBEEF, 16'h0};
        tbl[9]  = '{1, 4'h3, 16'hA5A5, 16'h1234, 16'h0000, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[10] = '{0, 4'h3, 16'h0000, 16'h1234, 16'hA5A5, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[11] = '{0, 4'h4, 16'h0000, 16'h0F0F, 16'h0F0F, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[12] = '{0, 4'h5, 16'h0000, 16'h0F0F, 16'h0008, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[13] = '{1, 4'h9, 16'hFFFF, 16'h0F0F, 16'h0000, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[14] = '{0, 4'h9, 16'h0000, 16'h0F0F, 16'h0000, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[15] = '{1, 4'h7, 16'hFFFF, 16'h0F0F, 16'h0000, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[16] = '{0, 4'h7, 16'h0000, 16'h0F0F, IRQ_ON ? 16'h001F : 16'h0000, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[17] = '{1, 4'h1, 16'h1111, 16'h0F0F, 16'h0000, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[18] = '{0, 4'h2, 16'h0000, 16'h0F0F, 16'hDEAD, 3'd2, 32'hDEADBEEF, 16'hA5A5};
        tbl[19] = '{0, 4'h1, 16'h0000, 16'h0F0F, 16'h1111, 3'd2, 32'hDEADBEEF, 16'hA5A5};

        reset_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1; switch_state = 16'h1234; button_state = 5'b01000;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_dc", {29'b0, display_control}, 0);
        chk("rst_seg", sevenseg_data, 0);
        chk("rst_led", {16'b0, mono_led_data}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst_ready", {31'b0, req_ready}, 1);

        // Button 3 held through reset must not appear as a press (row 0).
        for (int i = 0; i < 20; i++) begin
            switch_state = tbl[i].sw;
            xact(tbl[i].w, tbl[i].a, tbl[i].d, button_state, r);
            chk($sformatf("vec%0d_rdata", i), {16'b0, r}, {16'b0, tbl[i].er});
            chk($sformatf("vec%0d_dc", i), {29'b0, display_control}, {29'b0, tbl[i].edc});
            chk($sformatf("vec%0d_seg", i), sevenseg_data, tbl[i].eseg);
            chk($sformatf("vec%0d_led", i), {16'b0, mono_led_data}, {16'b0, tbl[i].eled});
        end

        xact(1, 4'h1, 16'h4321, button_state, r);
        xact(1, 4'h2, 16'h8765, button_state, r);
        chk("seg_before_commit", seg_pre, 32'hDEADBEEF);
        chk("seg_commit_next_cycle", seg_acc, 32'h87654321);

        @(negedge clk) button_state = 5'b01100;
        @(negedge clk) button_state = 5'b01000;
        repeat (2) @(negedge clk);
        xact(0, 4'h6, 16'h0, button_state, r);
        chk("press_b2", {16'b0, r}, 32'h0004);
        xact(0, 4'h6, 16'h0, button_state, r);
        chk("press_cleared", {16'b0, r}, 32'h0000);

        @(negedge clk) button_state = 5'b11000;
        @(negedge clk) button_state = 5'b01000;
        repeat (2) @(negedge clk);
        xact(0, 4'h6, 16'h0, 5'b01001, r);
        chk("press_race_old", {16'b0, r}, 32'h0010);
        xact(0, 4'h6, 16'h0, button_state, r);
        chk("press_race_new", {16'b0, r}, 32'h0001);

        switch_state = 16'h1234; resp_ready = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h4;
        @(posedge clk); #1; req_valid = 1'b0; switch_state = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rdata", {16'b0, resp_rdata}, 32'h1234);
            chk("hold_valid", {31'b0, resp_valid}, 1);
            chk("hold_ready", {31'b0, req_ready}, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", {31'b0, resp_valid}, 0);
        chk("hold_release_ready", {31'b0, req_ready}, 1);

        xact(1, 4'h7, 16'h0002, button_state, r);
        @(negedge clk) button_state = 5'b01011;
        @(posedge clk); #1 chk("irq_edge_plus1", {31'b0, irq}, 0);
        @(posedge clk); #1 chk("irq_edge_plus2", {31'b0, irq}, {31'b0, IRQ_ON});
        xact(1, 4'h6, 16'h0002, button_state, r);
        chk("irq_at_clear", {31'b0, irq_acc}, {31'b0, IRQ_ON});
        chk("irq_after_clear", {31'b0, irq}, 0);
        xact(0, 4'h6, 16'h0, button_state, r);
        chk("flags_after_wclear", {16'b0, r}, 32'h0000);

        resp_ready = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h0;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("pre_rst_valid", {31'b0, resp_valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, resp_valid}, 0);
        chk("midrst_ready", {31'b0, req_ready}, 0);
        chk("midrst_dc", {29'b0, display_control}, 0);
        chk("midrst_seg", sevenseg_data, 0);
        chk("midrst_led", {16'b0, mono_led_data}, 0);
        @(negedge clk); reset_n = 1'b1; resp_ready = 1'b1;
        #1 chk("midrst_recover", {31'b0, req_ready}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
